// File: rtl/huffman_frame_scheduler_pkg.sv
// Shared types and defaults for the huffman frame scheduler slice.
package huffman_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    LOAD   = 3'd2,
    ACTIVE = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

  localparam int PIXELS_PER_FRAME_DEF = 76800;
  localparam logic [1:0] PENDING_MAX = 2'd2;

endpackage

// File: rtl/huffman_frame_scheduler_bank_ctrl.sv
// Double-buffer bank ownership: front/back bank select, commit handshake and
// gating of the host write port into the back bank.
module huffman_bank_ctrl #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  host_commit,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [31:0]           host_wr_data,
  output logic                  host_wr_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH:0]   ram_wr_addr,
  output logic [31:0]           ram_wr_data,
  output logic                  rd_bank,
  output logic                  frame_ready
);

  logic rd_bank_d, rd_bank_q;
  logic commit_pending_d, commit_pending_q;
  logic have_frame_d, have_frame_q;

  // Swap on frame_start wins over a same-cycle commit, which is then dropped.
  always_comb begin
    rd_bank_d        = rd_bank_q;
    commit_pending_d = commit_pending_q;
    have_frame_d     = have_frame_q;
    if (frame_start && commit_pending_q) begin
      rd_bank_d        = ~rd_bank_q;
      commit_pending_d = 1'b0;
      have_frame_d     = 1'b1;
    end else if (host_commit) begin
      commit_pending_d = 1'b1;
    end else begin
      commit_pending_d = commit_pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q        <= 1'b0;
      commit_pending_q <= 1'b0;
      have_frame_q     <= 1'b0;
    end else begin
      rd_bank_q        <= rd_bank_d;
      commit_pending_q <= commit_pending_d;
      have_frame_q     <= have_frame_d;
    end
  end

  assign host_wr_ready = ~commit_pending_q;
  assign ram_wr_en     = host_wr_en & ~commit_pending_q;
  assign ram_wr_addr   = {~rd_bank_q, host_wr_addr};
  assign ram_wr_data   = host_wr_data;
  assign rd_bank       = rd_bank_q;
  // A frame is decodable after this edge if one is loaded or about to be swapped in.
  assign frame_ready   = have_frame_q | commit_pending_q;

endmodule

// File: rtl/huffman_frame_scheduler.sv
// Per-frame sequencer for a huffman_chunk_decoder: primes the decoder, then
// forwards display pixel strobes while honouring its load-cycle restriction.
module huffman_frame_scheduler
  import huffman_pkg::*;
#(
  parameter int ADDR_WIDTH       = 16,
  parameter int PIXELS_PER_FRAME = PIXELS_PER_FRAME_DEF,
  parameter int CNT_WIDTH        = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  pixel_strobe,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [31:0]           host_wr_data,
  input  logic                  host_commit,
  output logic                  host_wr_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH:0]   ram_wr_addr,
  output logic [31:0]           ram_wr_data,
  output logic                  rd_bank,
  output logic                  dec_pixel_reset,
  output logic                  dec_pixel_read_next,
  output logic                  color_valid,
  output logic                  frame_active,
  output logic                  sync_error,
  input  logic                  err_clear
);

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(PIXELS_PER_FRAME);

  sched_state_t         state_d, state_q;
  logic [1:0]           pending_d, pending_q;
  logic [CNT_WIDTH-1:0] count_d, count_q;
  logic                 read_next_d, read_next_q;
  logic                 color_valid_q;
  logic                 pixel_reset_d, pixel_reset_q;
  logic                 frame_active_d, frame_active_q;
  logic                 sync_error_d, sync_error_q;
  logic                 err_set_s;
  logic                 frame_ready;

  huffman_bank_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .host_commit   (host_commit),
    .host_wr_en    (host_wr_en),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_wr_ready (host_wr_ready),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .rd_bank       (rd_bank),
    .frame_ready   (frame_ready)
  );

  // Sequencing; frame_start overrides everything and drops a same-cycle strobe.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    count_d     = count_q;
    read_next_d = 1'b0;
    err_set_s   = 1'b0;
    if (frame_start) begin
      if ((state_q == PRIME) || (state_q == LOAD) || (state_q == ACTIVE)) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = 1'b0;
      end
      if (frame_ready) begin
        state_d   = PRIME;
        pending_d = 2'd0;
        count_d   = '0;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        PRIME, LOAD: begin
          state_d = (state_q == PRIME) ? LOAD : ACTIVE;
          // Strobes during priming are owed to the decoder once ACTIVE.
          if (pixel_strobe) begin
            if (pending_q == PENDING_MAX) begin
              err_set_s = 1'b1;
            end else begin
              pending_d = pending_q + 2'd1;
            end
          end else begin
            pending_d = pending_q;
          end
        end
        ACTIVE: begin
          read_next_d = (pending_q != 2'd0) | pixel_strobe;
          if ((pending_q != 2'd0) && !pixel_strobe) begin
            pending_d = pending_q - 2'd1;
          end else begin
            pending_d = pending_q;
          end
          if (read_next_d) begin
            count_d = count_q + CNT_WIDTH'(1);
            state_d = (count_d == LAST_COUNT) ? DONE : ACTIVE;
          end else begin
            state_d = ACTIVE;
          end
        end
        DONE: err_set_s = pixel_strobe;
        default: state_d = IDLE;
      endcase
    end

    if (err_set_s) begin
      sync_error_d = 1'b1;
    end else if (err_clear) begin
      sync_error_d = 1'b0;
    end else begin
      sync_error_d = sync_error_q;
    end
    pixel_reset_d  = (state_d == PRIME);
    frame_active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pending_q      <= 2'd0;
      count_q        <= '0;
      read_next_q    <= 1'b0;
      color_valid_q  <= 1'b0;
      pixel_reset_q  <= 1'b0;
      frame_active_q <= 1'b0;
      sync_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      count_q        <= count_d;
      read_next_q    <= read_next_d;
      color_valid_q  <= read_next_q;
      pixel_reset_q  <= pixel_reset_d;
      frame_active_q <= frame_active_d;
      sync_error_q   <= sync_error_d;
    end
  end

  assign dec_pixel_reset     = pixel_reset_q;
  assign dec_pixel_read_next = read_next_q;
  assign color_valid         = color_valid_q;
  assign frame_active        = frame_active_q;
  assign sync_error          = sync_error_q;

endmodule

// File: tb/tb_huffman_frame_scheduler.sv
// Directed table plus randomized traffic against a frame-level reference model.
module tb_huffman_frame_scheduler;

  localparam int AW  = 16;
  localparam int PPF = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0, pixel_strobe = 1'b0, host_wr_en = 1'b0;
  logic [AW-1:0] host_wr_addr = '0;
  logic [31:0]   host_wr_data = '0;
  logic          host_commit = 1'b0, err_clear = 1'b0;
  logic          host_wr_ready, ram_wr_en, rd_bank, dec_pixel_reset;
  logic          dec_pixel_read_next, color_valid, frame_active, sync_error;
  logic [AW:0]   ram_wr_addr;
  logic [31:0]   ram_wr_data;

  always #5 clk = ~clk;

  huffman_frame_scheduler #(.ADDR_WIDTH(AW), .PIXELS_PER_FRAME(PPF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_strobe(pixel_strobe),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_commit(host_commit), .host_wr_ready(host_wr_ready), .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .rd_bank(rd_bank),
    .dec_pixel_reset(dec_pixel_reset), .dec_pixel_read_next(dec_pixel_read_next),
    .color_valid(color_valid), .frame_active(frame_active), .sync_error(sync_error),
    .err_clear(err_clear)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: age = cycles since the last prime (-1 = nothing running),
  // owed = strobes not yet handed to the decoder, issued = reads this frame.
  logic m_rd, m_commit, m_have, m_rn, m_cv, m_err;
  int   m_age, m_issued, m_owed;

  typedef struct packed {
    logic       fs, ps, cm, ec, we;
    logic [6:0] exp;   // {rd_bank, pixel_reset, read_next, color_valid, active, sync_error, wr_ready}
  } vec_t;
  vec_t tbl [29];

  function automatic logic [6:0] dut_vec();
    return {rd_bank, dec_pixel_reset, dec_pixel_read_next, color_valid,
            frame_active, sync_error, host_wr_ready};
  endfunction

  function automatic logic [6:0] model_vec();
    logic running;
    running = (m_age >= 2) && (m_issued < PPF);
    return {m_rd, (m_age == 0), m_rn, m_cv, running, m_err, ~m_commit};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = 1'b0; m_commit = 1'b0; m_have = 1'b0;
    m_rn = 1'b0; m_cv = 1'b0; m_err = 1'b0;
    m_age = -1; m_issued = 0; m_owed = 0;
  endtask

  task automatic step(input logic fs, input logic ps, input logic cm, input logic ec,
                      input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
    logic err, rn, busy;
    frame_start = fs; pixel_strobe = ps; host_commit = cm; err_clear = ec;
    host_wr_en = we; host_wr_addr = wa; host_wr_data = wd;
    #1;
    check("ram_wr_en", 32'(ram_wr_en), 32'(we & ~m_commit));
    check("ram_wr_addr", 32'(ram_wr_addr), 32'({~m_rd, wa}));
    check("ram_wr_data", ram_wr_data, wd);

    err = 1'b0; rn = 1'b0;
    busy = (m_age >= 0) && !((m_age >= 2) && (m_issued == PPF));
    if (fs && m_commit) begin
      m_rd = ~m_rd; m_commit = 1'b0; m_have = 1'b1;
    end else if (cm) begin
      m_commit = 1'b1;
    end
    if (fs) begin
      if (busy) err = 1'b1;
      if (m_have) begin m_age = 0; m_issued = 0; m_owed = 0; end
    end else if (m_age == 0 || m_age == 1) begin
      if (ps) begin
        if (m_owed == 2) err = 1'b1;
        else m_owed++;
      end
      m_age++;
    end else if (m_age >= 2) begin
      if (m_issued == PPF) begin
        if (ps) err = 1'b1;
      end else begin
        rn = (m_owed > 0) || ps;
        m_owed = m_owed + int'(ps) - int'(rn);
        m_issued = m_issued + int'(rn);
      end
    end
    if (err) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    m_cv = m_rn;
    m_rn = rn;

    @(posedge clk);
    @(negedge clk);
    check("outputs", 32'(dut_vec()), 32'(model_vec()));
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_hold", 32'(dut_vec()), 32'(7'b0000001));
    check("reset_wr_addr_msb", 32'(ram_wr_addr[AW]), 32'(1'b1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //                fs    ps    cm    ec    we    expected
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000001};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000001};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000001};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100001};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000001};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000101};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010101};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1011101};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1011101};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1001101};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010001};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1001011};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000001};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100001};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000001};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000101};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010101};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1011101};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1101011};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000001};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000101};
    tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010101};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1011101};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1011101};
    tbl[26] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1011001};
    tbl[27] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1001011};
    tbl[28] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000001};

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].fs, tbl[i].ps, tbl[i].cm, tbl[i].ec, tbl[i].we,
           AW'(i * 3), 32'hC0DE_0000 + 32'(i));
      check($sformatf("table_row_%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // Reset while ACTIVE with a commit outstanding drops everything.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check("pre_reset_active", 32'({frame_active, host_wr_ready}), 32'(2'b10));
    pixel_strobe = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_frame_reset", 32'(dut_vec()), 32'(7'b0000001));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), AW'($urandom), $urandom);
    end
    frame_start = 1'b0; pixel_strobe = 1'b0; host_commit = 1'b0;
    err_clear = 1'b0; host_wr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
